// File: rtl/q_update_ctrl.sv
// Q-table TD-update controller: reads Q(s,a) and Q(s',*) from the action RAM,
// computes the Q8.8 update and writes Q(s,a) back. It also reports argmax Q(s',*).
module q_update_ctrl #(
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned GAMMA_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [STATE_W-1:0]   state,
    input  logic [1:0]           action,
    input  logic [STATE_W-1:0]   next_state,
    input  logic [DATA_W-1:0]    reward,
    input  logic                 terminal,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    q_new,
    output logic [1:0]           best_next_action,
    output logic                 ram_en,
    output logic [STATE_W+1:0]   ram_rd_addr,
    output logic [STATE_W+1:0]   ram_wr_addr,
    output logic                 ram_we,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);
    localparam int unsigned ADDR_W = STATE_W + 2;
    localparam int unsigned INT_W  = DATA_W + 3;
    localparam int unsigned EXT_W  = INT_W - DATA_W;
    localparam logic signed [INT_W-1:0] SAT_HI = INT_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [INT_W-1:0] SAT_LO = INT_W'(-(1 << (DATA_W - 1)));

    typedef enum logic [3:0] {
        S_IDLE, S_RD_Q, S_RD_N0, S_RD_N1, S_RD_N2, S_RD_N3,
        S_WAIT, S_CALC, S_WRITE, S_DONE
    } fsm_t;

    fsm_t fsm_q, fsm_d;

    logic [STATE_W-1:0]       s_q, sn_q;
    logic [1:0]               a_q;
    logic signed [DATA_W-1:0] r_q, q_old_q, max_q;
    logic                     term_q;
    logic [1:0]               best_q;

    logic                     busy_d, done_d, ram_en_d, ram_we_d;
    logic [ADDR_W-1:0]        rd_addr_d;

    logic signed [INT_W-1:0]  m_x, r_x, q_x, tgt_x, err_x, sum_x;
    logic [DATA_W-1:0]        q_sat;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next state plus next values of the registered control outputs
    always_comb begin
        fsm_d     = fsm_q;
        rd_addr_d = ram_rd_addr;
        case (fsm_q)
            S_IDLE:  if (start) fsm_d = S_RD_Q;
            S_RD_Q:  fsm_d = S_RD_N0;
            S_RD_N0: fsm_d = S_RD_N1;
            S_RD_N1: fsm_d = S_RD_N2;
            S_RD_N2: fsm_d = S_RD_N3;
            S_RD_N3: fsm_d = S_WAIT;
            S_WAIT:  fsm_d = S_CALC;
            S_CALC:  fsm_d = S_WRITE;
            S_WRITE: fsm_d = S_DONE;
            S_DONE:  fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase

        case (fsm_d)
            S_RD_Q:  rd_addr_d = {state, action};
            S_RD_N0: rd_addr_d = {sn_q, 2'd0};
            S_RD_N1: rd_addr_d = {sn_q, 2'd1};
            S_RD_N2: rd_addr_d = {sn_q, 2'd2};
            S_RD_N3: rd_addr_d = {sn_q, 2'd3};
            default: rd_addr_d = ram_rd_addr;
        endcase

        busy_d   = (fsm_d != S_IDLE);
        done_d   = (fsm_d == S_DONE);
        ram_we_d = (fsm_d == S_WRITE);
        ram_en_d = (fsm_d == S_RD_Q)  || (fsm_d == S_RD_N0) || (fsm_d == S_RD_N1) ||
                   (fsm_d == S_RD_N2) || (fsm_d == S_RD_N3);
    end

    // TD update in widened signed arithmetic, then clamp to the Q8.8 range
    always_comb begin
        m_x   = term_q ? '0 : {{EXT_W{max_q[DATA_W-1]}}, max_q};
        r_x   = {{EXT_W{r_q[DATA_W-1]}}, r_q};
        q_x   = {{EXT_W{q_old_q[DATA_W-1]}}, q_old_q};
        tgt_x = r_x + m_x - (m_x >>> GAMMA_SHIFT);
        err_x = tgt_x - q_x;
        sum_x = q_x + (err_x >>> ALPHA_SHIFT);
        if (sum_x > SAT_HI) begin
            q_sat = SAT_HI[DATA_W-1:0];
        end else if (sum_x < SAT_LO) begin
            q_sat = SAT_LO[DATA_W-1:0];
        end else begin
            q_sat = sum_x[DATA_W-1:0];
        end
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_rd_addr <= '0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            ram_en      <= ram_en_d;
            ram_we      <= ram_we_d;
            ram_rd_addr <= rd_addr_d;
        end
    end

    // Operand capture, running max (strict > keeps the lowest index on ties), result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q              <= '0;
            sn_q             <= '0;
            a_q              <= '0;
            r_q              <= '0;
            term_q           <= 1'b0;
            q_old_q          <= '0;
            max_q            <= '0;
            best_q           <= '0;
            q_new            <= '0;
            best_next_action <= '0;
            ram_wr_addr      <= '0;
            ram_wdata        <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (start) begin
                        s_q    <= state;
                        a_q    <= action;
                        sn_q   <= next_state;
                        r_q    <= reward;
                        term_q <= terminal;
                    end
                end
                S_RD_N0: q_old_q <= ram_rdata;
                S_RD_N1: begin
                    max_q  <= ram_rdata;
                    best_q <= 2'd0;
                end
                S_RD_N2, S_RD_N3, S_WAIT: begin
                    if ($signed(ram_rdata) > max_q) begin
                        max_q  <= ram_rdata;
                        best_q <= (fsm_q == S_RD_N2) ? 2'd1 :
                                  (fsm_q == S_RD_N3) ? 2'd2 : 2'd3;
                    end
                end
                S_CALC: begin
                    q_new            <= q_sat;
                    ram_wdata        <= q_sat;
                    ram_wr_addr      <= {s_q, a_q};
                    best_next_action <= best_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_q_update_ctrl.sv
// Bench for q_update_ctrl: behavioural RAM plus arithmetic reference model,
// directed spec cases followed by randomized updates.
module tb_q_update_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  state = '0;
    logic [1:0]  action = '0;
    logic [3:0]  next_state = '0;
    logic [15:0] reward = '0;
    logic        terminal = 1'b0;
    logic        busy, done, ram_en, ram_we;
    logic [15:0] q_new, ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic [1:0]  best_next_action;
    logic [5:0]  ram_rd_addr, ram_wr_addr;

    logic [15:0] mem [64];
    logic [15:0] ref_mem [64];
    logic        tb_we = 1'b0;
    logic [5:0]  tb_addr = '0;
    logic [15:0] tb_data = '0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    q_update_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .state(state), .action(action),
        .next_state(next_state), .reward(reward), .terminal(terminal),
        .busy(busy), .done(done), .q_new(q_new), .best_next_action(best_next_action),
        .ram_en(ram_en), .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Action RAM with one-cycle registered read; the bench preloads through tb_we
    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_rd_addr];
        if (ram_we) mem[ram_wr_addr] <= ram_wdata;
        if (tb_we)  mem[tb_addr] <= tb_data;
        if (ram_we) we_cnt <= we_cnt + 1;
        if (done)   done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [5:0] addr, input logic [15:0] data);
        tb_we = 1'b1; tb_addr = addr; tb_data = data;
        tick();
        tb_we = 1'b0;
        ref_mem[addr] = data;
    endtask

    function automatic int floor_div(input int x, input int d);
        return (x >= 0) ? x / d : -((-x + d - 1) / d);
    endfunction

    function automatic int sv16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Reference: alpha = 1/4, gamma = 7/8, floor rounding, clamp to 16-bit signed
    task automatic model(input logic [3:0] s, input logic [1:0] a, input logic [3:0] sn,
                         input logic [15:0] r, input logic term,
                         output logic [15:0] q_exp, output logic [1:0] best_exp);
        int best_v, m, tgt, nv, qv;
        qv = sv16(ref_mem[{s, a}]);
        best_v = sv16(ref_mem[{sn, 2'd0}]);
        best_exp = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (sv16(ref_mem[{sn, 2'(i)}]) > best_v) begin
                best_v = sv16(ref_mem[{sn, 2'(i)}]);
                best_exp = 2'(i);
            end
        end
        m   = term ? 0 : best_v;
        tgt = sv16(r) + m - floor_div(m, 8);
        nv  = qv + floor_div(tgt - qv, 4);
        if (nv > 32767)  nv = 32767;
        if (nv < -32768) nv = -32768;
        q_exp = 16'(nv);
    endtask

    task automatic run_op(input string tag, input logic [3:0] s, input logic [1:0] a,
                          input logic [3:0] sn, input logic [15:0] r, input logic term,
                          input logic extra_starts);
        logic [15:0] q_exp;
        logic [1:0]  best_exp;
        int we0, d0, done_at, we_at;
        logic busy_after;
        model(s, a, sn, r, term, q_exp, best_exp);
        we0 = we_cnt; d0 = done_cnt; done_at = 0; we_at = 0; busy_after = 1'bx;
        state = s; action = a; next_state = sn; reward = r; terminal = term; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_acc"}, 32'(busy), 32'd1);
        for (int n = 1; n <= 16; n++) begin
            if (ram_we && we_at == 0) we_at = n;
            if (done && done_at == 0) done_at = n;
            if (n == 10) busy_after = busy;
            start = extra_starts && (n == 3 || n == 9);
            tick();
        end
        start = 1'b0;
        ref_mem[{s, a}] = q_exp;
        check({tag, "_done_lat"}, 32'(done_at), 32'd9);
        check({tag, "_we_lat"}, 32'(we_at), 32'd8);
        check({tag, "_busy_end"}, 32'(busy_after), 32'd0);
        check({tag, "_q_new"}, 32'(q_new), 32'(q_exp));
        check({tag, "_best"}, 32'(best_next_action), 32'(best_exp));
        check({tag, "_mem"}, 32'(mem[{s, a}]), 32'(q_exp));
        check({tag, "_we_cnt"}, 32'(we_cnt - we0), 32'd1);
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        logic [3:0]  rs, rsn;
        logic [1:0]  ra;
        logic [15:0] rv;
        int we0, d0;

        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_en", 32'(ram_en), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_outs", {q_new, ram_wdata}, 32'd0);
        check("rst_addr", {18'd0, best_next_action, ram_rd_addr, ram_wr_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Case 1 and 2: tie on max, then the same with terminal
        poke(6'd6, 16'h0100);
        poke(6'd12, 16'h0000); poke(6'd13, 16'h0200); poke(6'd14, 16'h0080); poke(6'd15, 16'h0200);
        run_op("t1", 4'd1, 2'd2, 4'd3, 16'h0100, 1'b0, 1'b0);
        check("t1_lit_q", 32'(q_new), 32'h0170);
        check("t1_lit_best", 32'(best_next_action), 32'd1);
        poke(6'd6, 16'h0100);
        run_op("t2", 4'd1, 2'd2, 4'd3, 16'h0100, 1'b1, 1'b0);
        check("t2_lit_q", 32'(q_new), 32'h0100);

        // Case 3: positive saturation
        poke(6'd20, 16'h7F00);
        for (int i = 0; i < 4; i++) poke(6'(40 + i), 16'h7FFF);
        run_op("t3", 4'd5, 2'd0, 4'd10, 16'h7FFF, 1'b0, 1'b0);
        check("t3_lit_q", 32'(q_new), 32'h7FFF);

        // Case 4: negative error floors toward -inf
        poke(6'd33, 16'h0000);
        run_op("t4", 4'd8, 2'd1, 4'd2, 16'hFC00, 1'b1, 1'b0);
        check("t4_lit_q", 32'(q_new), 32'hFF00);

        // Case 5: reset during RD_N2 aborts without a write
        poke(6'd50, 16'h1234);
        for (int i = 0; i < 4; i++) poke(6'(i), 16'h0400);
        we0 = we_cnt; d0 = done_cnt;
        state = 4'd12; action = 2'd2; next_state = 4'd0; reward = 16'h0100; terminal = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_en_rst", 32'(ram_en), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) tick();
        check("t5_we_none", 32'(we_cnt - we0), 32'd0);
        check("t5_done_none", 32'(done_cnt - d0), 32'd0);
        check("t5_mem", 32'(mem[50]), 32'h1234);
        run_op("t5b", 4'd12, 2'd2, 4'd0, 16'h0100, 1'b0, 1'b0);

        // Case 6: start pulses during RD_N1 and DONE are ignored
        run_op("t6", 4'd12, 2'd2, 4'd0, 16'hFF80, 1'b0, 1'b1);
        we0 = we_cnt;
        for (int n = 0; n < 12; n++) tick();
        check("t6_no_extra_we", 32'(we_cnt - we0), 32'd0);

        // Randomized updates, including s == s' and tie-prone small values
        for (int k = 0; k < 30; k++) begin
            rs  = 4'($urandom);
            ra  = 2'($urandom);
            rsn = ($urandom_range(0, 4) == 0) ? rs : 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                rv = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 3)) << 8 : 16'($urandom);
                poke({rsn, 2'(i)}, rv);
            end
            if (rs != rsn) poke({rs, ra}, 16'($urandom));
            run_op("rnd", rs, ra, rsn, 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
